// File: rtl/frame_reader_pkg.sv
// Shared types and constants for the frame_reader scan-out block.
// The RGB565 palette is used only when FRAME_READER_PALETTE_EN is defined.
package frame_reader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_STREAM,
        ST_DRAIN
    } state_t;

    // One output beat as carried through the 2-entry output buffer
    typedef struct packed {
        logic [15:0] data;
        logic [9:0]  x;
        logic [8:0]  y;
        logic        last;
    } pix_t;

    // Iteration count 0..15 mapped onto a dark-blue -> cyan -> yellow -> red -> white ramp
    localparam logic [15:0] PALETTE [16] = '{
        16'h0000, 16'h0010, 16'h0018, 16'h001F,
        16'h041F, 16'h07FF, 16'h07F0, 16'h07E0,
        16'h3FE0, 16'h7FE0, 16'hFFE0, 16'hFD20,
        16'hFA00, 16'hF800, 16'hF81F, 16'hFFFF
    };

    function automatic int pixel_count(input int width, input int height);
        return width * height;
    endfunction

endpackage

// File: rtl/frame_reader_skid.sv
// Two-entry valid/ready buffer between the RAM read pipeline and the pixel sink.
// Upstream never pushes into a full buffer; the read issuer budgets credits from count.
module frame_reader_skid
    import frame_reader_pkg::*;
(
    input  logic       clock,
    input  logic       reset_n,
    input  logic       in_valid,
    input  pix_t       in_pix,
    output logic       out_valid,
    input  logic       out_ready,
    output pix_t       out_pix,
    output logic [1:0] count
);

    pix_t       entry_q [2];
    logic       wr_ptr_q;
    logic       rd_ptr_q;
    logic [1:0] count_q;
    logic       pop;

    assign pop       = out_valid && out_ready;
    assign out_valid = (count_q != 2'd0);
    assign out_pix   = entry_q[rd_ptr_q];
    assign count     = count_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            // NOTE: the storage is reset too, because pix_data/pix_x/pix_y are read straight from it and must be zero in reset
            entry_q[0] <= '0;
            entry_q[1] <= '0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            count_q    <= 2'd0;
        end else begin
            if (in_valid) begin
                entry_q[wr_ptr_q] <= in_pix;
                wr_ptr_q          <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            case ({in_valid, pop})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end

    no_overflow: assert property (@(posedge clock) disable iff (!reset_n)
        !(in_valid && (count_q == 2'd2) && !pop));

endmodule

// File: rtl/frame_reader.sv
// Scans one frame out of NUM_SOLVERS interleaved iteration RAMs as a valid/ready pixel stream.
// Define FRAME_READER_PALETTE_EN to map iteration values through the RGB565 palette.
module frame_reader
    import frame_reader_pkg::*;
#(
    parameter int NUM_SOLVERS = 1,
    parameter int WIDTH       = 640,
    parameter int HEIGHT      = 480
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              start,
    input  logic              solve_done,
    output logic [5:0]        rd_solver_id,
    output logic [18:0]       rd_addr,
    input  logic signed [3:0] rd_data_in,
    output logic              pix_valid,
    input  logic              pix_ready,
    output logic [15:0]       pix_data,
    output logic [9:0]        pix_x,
    output logic [8:0]        pix_y,
    output logic              pix_last,
    output logic              busy
);

    localparam int          NUM_PIXELS  = pixel_count(WIDTH, HEIGHT);
    localparam logic [5:0]  BANK_LAST   = 6'(NUM_SOLVERS - 1);
    localparam logic [9:0]  X_LAST      = 10'(WIDTH - 1);
    localparam logic [19:0] REMAIN_INIT = 20'(NUM_PIXELS - 1);

    state_t      state_q, state_d;

    // Read-side raster position: the pixel whose bank/address sits on the RAM port
    logic [5:0]  bank_q;
    logic [18:0] addr_q;
    logic [9:0]  x_q;
    logic [8:0]  y_q;
    logic [19:0] remain_q;

    // Coordinates of the read whose data returns this cycle
    logic        fly_q;
    logic [9:0]  fly_x_q;
    logic [8:0]  fly_y_q;
    logic        fly_last_q;

    logic        issue;
    logic        is_last;
    logic        frame_go;
    logic        pop;
    logic [1:0]  buf_count;
    logic [2:0]  occupancy;
    logic [15:0] mapped;
    pix_t        push_pix;
    pix_t        out_pix;

    assign is_last  = (remain_q == 20'd0);
    assign frame_go = (state_q == ST_IDLE) && start;
    assign pop      = pix_valid && pix_ready;

    // Entries left after this cycle's handshake plus the read in flight; counting the
    // pop here is what lets a full-rate sink see one pixel per cycle.
    assign occupancy = {1'b0, buf_count} - {2'b00, pop} + {2'b00, fly_q};

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            // NOTE: sequential state uses <= so every register samples pre-edge values
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        // NOTE: defaults first, so no branch leaves state_d or issue unassigned (no latch)
        state_d = state_q;
        issue   = 1'b0;
        unique case (state_q)
            ST_IDLE:   if (start)      state_d = ST_WAIT;
            ST_WAIT:   if (solve_done) state_d = ST_STREAM;
            ST_STREAM: begin
                issue = (occupancy < 3'd2);
                if (issue && is_last) state_d = ST_DRAIN;
            end
            ST_DRAIN:  if (pop && pix_last) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Counters move only when a read is issued; after the final read they hold it.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            bank_q   <= '0;
            addr_q   <= '0;
            x_q      <= '0;
            y_q      <= '0;
            remain_q <= '0;
        end else if (frame_go) begin
            bank_q   <= '0;
            addr_q   <= '0;
            x_q      <= '0;
            y_q      <= '0;
            remain_q <= REMAIN_INIT;
        end else if (issue && !is_last) begin
            remain_q <= remain_q - 20'd1;
            if (bank_q == BANK_LAST) begin
                bank_q <= '0;
                addr_q <= addr_q + 19'd1;
            end else begin
                bank_q <= bank_q + 6'd1;
            end
            if (x_q == X_LAST) begin
                x_q <= '0;
                y_q <= y_q + 9'd1;
            end else begin
                x_q <= x_q + 10'd1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            fly_q      <= 1'b0;
            fly_x_q    <= '0;
            fly_y_q    <= '0;
            fly_last_q <= 1'b0;
        end else begin
            fly_q <= issue;
            if (issue) begin
                fly_x_q    <= x_q;
                fly_y_q    <= y_q;
                fly_last_q <= is_last;
            end
        end
    end

`ifdef FRAME_READER_PALETTE_EN
    assign mapped = PALETTE[$unsigned(rd_data_in)];
`else
    assign mapped = {12'h000, rd_data_in};
`endif

    assign push_pix = '{data: mapped, x: fly_x_q, y: fly_y_q, last: fly_last_q};

    frame_reader_skid u_skid (
        .clock     (clock),
        .reset_n   (reset_n),
        .in_valid  (fly_q),
        .in_pix    (push_pix),
        .out_valid (pix_valid),
        .out_ready (pix_ready),
        .out_pix   (out_pix),
        .count     (buf_count)
    );

    assign rd_solver_id = bank_q;
    assign rd_addr      = addr_q;
    assign pix_data     = out_pix.data;
    assign pix_x        = out_pix.x;
    assign pix_y        = out_pix.y;
    assign pix_last     = out_pix.last;
    assign busy         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_frame_reader.sv
// Bench for frame_reader (4 banks, 8x2 frame) against a synchronous-RAM model and a
// raster-order reference of the expected pixel stream.
`timescale 1ns/1ps
module tb_frame_reader;
`ifdef FRAME_READER_PALETTE_EN
    import frame_reader_pkg::*;
`endif

    localparam int N_SOL   = 4;
    localparam int W       = 8;
    localparam int H       = 2;
    localparam int NUM_PIX = W * H;
    localparam int DEPTH   = NUM_PIX / N_SOL;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        solve_done = 1'b0;
    logic        pix_ready = 1'b0;
    logic [5:0]  rd_solver_id;
    logic [18:0] rd_addr;
    logic [3:0]  rd_data_in = 4'h0;
    logic        pix_valid;
    logic [15:0] pix_data;
    logic [9:0]  pix_x;
    logic [8:0]  pix_y;
    logic        pix_last;
    logic        busy;

    logic [3:0]  ram [N_SOL][DEPTH];
    logic [3:0]  frame_val [NUM_PIX];
    int          checks = 0;
    int          failures = 0;

    always #5 clock = ~clock;

    frame_reader #(.NUM_SOLVERS(N_SOL), .WIDTH(W), .HEIGHT(H)) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .start        (start),
        .solve_done   (solve_done),
        .rd_solver_id (rd_solver_id),
        .rd_addr      (rd_addr),
        .rd_data_in   (rd_data_in),
        .pix_valid    (pix_valid),
        .pix_ready    (pix_ready),
        .pix_data     (pix_data),
        .pix_x        (pix_x),
        .pix_y        (pix_y),
        .pix_last     (pix_last),
        .busy         (busy)
    );

    // Synchronous RAM banks: data appears one cycle after bank/address are presented
    always @(posedge clock) begin : ram_model
        int b;
        int a;
        b = int'(rd_solver_id);
        a = int'(rd_addr);
        rd_data_in <= (b < N_SOL && a < DEPTH) ? ram[b][a] : 4'h0;
    end

    function automatic logic [15:0] exp_pix(input logic [3:0] v);
`ifdef FRAME_READER_PALETTE_EN
        return PALETTE[v];
`else
        return {12'h000, v};
`endif
    endfunction

    // One frame: wait_cycles=0 means solve_done already high at start; ready_mode 0=always,
    // 1=pattern 1,0,0,1, 2=random; restart_at/abort_at < 0 disable those events.
    task automatic run_frame(input string name, input int wait_cycles, input int ready_mode,
                             input int restart_at, input bit drop_done, input int abort_at,
                             input bit all_f);
        int          got;
        int          first_valid;
        int          last_hs;
        int          exp_first;
        int          wait_end;
        bit          stalled;
        bit          restarted;
        logic [15:0] snap_data;
        logic [9:0]  snap_x;
        logic [8:0]  snap_y;
        logic        snap_last;
        logic [15:0] exp_data;

        for (int p = 0; p < NUM_PIX; p++) begin
            frame_val[p] = all_f ? 4'hF : 4'($urandom_range(0, 15));
            ram[p % N_SOL][p / N_SOL] = frame_val[p];
        end
        exp_first = (wait_cycles == 0) ? 4 : wait_cycles + 3;
        wait_end  = (wait_cycles == 0) ? 1 : wait_cycles;
        got = 0; first_valid = -1; last_hs = -1; stalled = 1'b0; restarted = 1'b0;
        snap_data = '0; snap_x = '0; snap_y = '0; snap_last = 1'b0;

        @(negedge clock);
        solve_done = (wait_cycles == 0);
        pix_ready  = 1'b0;
        start      = 1'b1;

        for (int cyc = 1; cyc <= 400 && got < NUM_PIX; cyc++) begin
            @(negedge clock);
            start = 1'b0;

            if (abort_at >= 0 && got == abort_at) begin
                reset_n = 1'b0;
                #1;
                checks++;
                if (pix_valid !== 1'b0 || busy !== 1'b0 || rd_solver_id !== 6'd0 || rd_addr !== 19'd0) begin
                    failures++;
                    $display("FAIL %s_abort_reset: valid=%0b busy=%0b bank=%0d addr=%0d, want all 0",
                             name, pix_valid, busy, rd_solver_id, rd_addr);
                end
                @(negedge clock);
                @(negedge clock);
                checks++;
                if (pix_valid !== 1'b0) begin
                    failures++;
                    $display("FAIL %s_valid_in_reset: valid=%0b, want 0", name, pix_valid);
                end
                reset_n = 1'b1;
                return;
            end

            if (cyc < exp_first) begin
                checks++;
                if (pix_valid !== 1'b0 || busy !== 1'b1) begin
                    failures++;
                    $display("FAIL %s_pre_stream: cyc=%0d valid=%0b busy=%0b, want valid=0 busy=1",
                             name, cyc, pix_valid, busy);
                end
            end
            if (cyc <= wait_end) begin
                checks++;
                if (rd_solver_id !== 6'd0 || rd_addr !== 19'd0) begin
                    failures++;
                    $display("FAIL %s_wait_port: cyc=%0d bank=%0d addr=%0d, want 0/0",
                             name, cyc, rd_solver_id, rd_addr);
                end
            end

            if (stalled) begin
                checks++;
                if (pix_valid !== 1'b1 ||
                    {pix_data, pix_x, pix_y, pix_last} !== {snap_data, snap_x, snap_y, snap_last}) begin
                    failures++;
                    $display("FAIL %s_stall_hold: valid=%0b data=%h x=%0d y=%0d, want valid=1 data=%h x=%0d y=%0d",
                             name, pix_valid, pix_data, pix_x, pix_y, snap_data, snap_x, snap_y);
                end
            end

            if (pix_valid === 1'b1 && first_valid < 0) first_valid = cyc;

            case (ready_mode)
                0:       pix_ready = 1'b1;
                1:       pix_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
                default: pix_ready = 1'($urandom_range(0, 1));
            endcase

            stalled = (pix_valid === 1'b1) && !pix_ready;
            if (stalled) begin
                snap_data = pix_data; snap_x = pix_x; snap_y = pix_y; snap_last = pix_last;
            end

            if (pix_valid === 1'b1 && pix_ready) begin
                exp_data = exp_pix(frame_val[got]);
                checks++;
                if (pix_data !== exp_data || pix_x !== 10'(got % W) || pix_y !== 9'(got / W) ||
                    pix_last !== (got == NUM_PIX - 1) || busy !== 1'b1) begin
                    failures++;
                    $display("FAIL %s_pixel%0d: data=%h x=%0d y=%0d last=%0b busy=%0b, want data=%h x=%0d y=%0d last=%0b busy=1",
                             name, got, pix_data, pix_x, pix_y, pix_last, busy,
                             exp_data, got % W, got / W, got == NUM_PIX - 1);
                end
                got++;
                last_hs = cyc;
            end

            if (wait_cycles > 0 && cyc == wait_cycles) solve_done = 1'b1;
            if (drop_done && first_valid >= 0) solve_done = 1'b0;
            if (restart_at >= 0 && got == restart_at && !restarted) begin
                start     = 1'b1;
                restarted = 1'b1;
            end
        end

        if (got < NUM_PIX) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout: got %0d pixels, want %0d", name, got, NUM_PIX);
            return;
        end

        checks++;
        if (first_valid != exp_first) begin
            failures++;
            $display("FAIL %s_first_valid: cycle %0d, want %0d", name, first_valid, exp_first);
        end
        if (ready_mode == 0) begin
            checks++;
            if (last_hs - first_valid != NUM_PIX - 1) begin
                failures++;
                $display("FAIL %s_throughput: %0d cycles first..last, want %0d",
                         name, last_hs - first_valid, NUM_PIX - 1);
            end
        end

        @(negedge clock);
        start = 1'b0;
        checks++;
        if (busy !== 1'b0 || pix_valid !== 1'b0) begin
            failures++;
            $display("FAIL %s_idle_after: busy=%0b valid=%0b, want 0/0", name, busy, pix_valid);
        end
        checks++;
        if (rd_solver_id !== 6'((NUM_PIX - 1) % N_SOL) || rd_addr !== 19'((NUM_PIX - 1) / N_SOL)) begin
            failures++;
            $display("FAIL %s_rd_hold: bank=%0d addr=%0d, want %0d/%0d", name, rd_solver_id, rd_addr,
                     (NUM_PIX - 1) % N_SOL, (NUM_PIX - 1) / N_SOL);
        end
        if (restart_at >= 0) begin
            repeat (6) @(negedge clock);
            checks++;
            if (busy !== 1'b0 || pix_valid !== 1'b0) begin
                failures++;
                $display("FAIL %s_restart_ignored: busy=%0b valid=%0b, want 0/0", name, busy, pix_valid);
            end
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0; start = 1'b0; solve_done = 1'b0; pix_ready = 1'b0;
        repeat (2) @(negedge clock);
        checks++;
        if (pix_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: %0b, want 0", pix_valid); end
        checks++;
        if (pix_last !== 1'b0) begin failures++; $display("FAIL reset_last: %0b, want 0", pix_last); end
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: %0b, want 0", busy); end
        checks++;
        if (rd_solver_id !== 6'd0) begin failures++; $display("FAIL reset_bank: %0d, want 0", rd_solver_id); end
        checks++;
        if (rd_addr !== 19'd0) begin failures++; $display("FAIL reset_addr: %0d, want 0", rd_addr); end
        checks++;
        if (pix_x !== 10'd0 || pix_y !== 9'd0) begin
            failures++; $display("FAIL reset_xy: x=%0d y=%0d, want 0/0", pix_x, pix_y);
        end
        checks++;
        if (pix_data !== 16'h0000) begin failures++; $display("FAIL reset_data: %h, want 0000", pix_data); end
        reset_n = 1'b1;
        solve_done = 1'b1;
        repeat (4) @(negedge clock);
        checks++;
        if (busy !== 1'b0 || pix_valid !== 1'b0) begin
            failures++; $display("FAIL no_start_idle: busy=%0b valid=%0b, want 0/0", busy, pix_valid);
        end
    endtask

    task automatic test_basic_stream();
        run_frame("basic", 0, 0, -1, 1'b0, -1, 1'b0);
    endtask

    task automatic test_wait_solve();
        solve_done = 1'b0;
        run_frame("wait10", 10, 0, -1, 1'b0, -1, 1'b0);
    endtask

    task automatic test_backpressure();
        run_frame("pattern1001", 0, 1, -1, 1'b0, -1, 1'b0);
    endtask

    task automatic test_random_ready_done_drop();
        run_frame("random_drop", 0, 2, -1, 1'b1, -1, 1'b0);
    endtask

    task automatic test_restart_ignored();
        run_frame("restart", 0, 0, 6, 1'b0, -1, 1'b0);
    endtask

    task automatic test_reset_mid_frame();
        run_frame("abort", 0, 0, -1, 1'b0, 5, 1'b0);
        run_frame("after_abort", 0, 0, -1, 1'b0, -1, 1'b0);
    endtask

    task automatic test_all_f();
        run_frame("all_f", 0, 0, -1, 1'b0, -1, 1'b1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic_stream();
        test_wait_solve();
        test_backpressure();
        test_random_ready_done_drop();
        test_restart_ignored();
        test_reset_mid_frame();
        test_all_f();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/frame_reader.md
FRAME_READER -- requirements
Module: frame_reader

Interface
REQ-001 Parameter NUM_SOLVERS, default 1, number of interleaved solver RAMs (1..64).
REQ-002 Parameter WIDTH, default 640, pixels per line.
REQ-003 Parameter HEIGHT, default 480, lines per frame.
REQ-004 clock  input  1  sole clock; all logic on rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 start  input  1  one-cycle pulse requesting one frame scan-out.
REQ-007 solve_done  input  1  all solvers finished (from multi_solver done).
REQ-008 rd_solver_id  output  6  RAM bank select.
REQ-009 rd_addr  output  19  word address within selected bank.
REQ-010 rd_data_in  input  4  signed iteration value, valid exactly 1 cycle after rd_solver_id/rd_addr are presented.
REQ-011 pix_valid  output  1  pix_data/pix_x/pix_y/pix_last valid.
REQ-012 pix_ready  input  1  sink accepts when pix_valid & pix_ready.
REQ-013 pix_data  output  16  pixel value (RGB565 or raw, per REQ-032/033).
REQ-014 pix_x  output  10 / pix_y  output  9  coordinates of current pixel.
REQ-015 pix_last  output  1  high on final pixel (WIDTH-1, HEIGHT-1).
REQ-016 busy  output  1  high from accepted start until last pixel handshake.

Function
REQ-017 Linear pixel index p = y*WIDTH + x, raster order, x fastest; pixel p SHALL be read from bank p mod NUM_SOLVERS at address p div NUM_SOLVERS.
REQ-018 Bank/address SHALL be generated by counters (bank increments, wraps at NUM_SOLVERS-1 to 0 and increments address); no divider.
REQ-019 FSM states IDLE, WAIT, STREAM, DRAIN.
REQ-020 IDLE -> WAIT on start; start in any other state SHALL be ignored.
REQ-021 WAIT -> STREAM on first cycle solve_done=1 (same cycle as start if already high -> WAIT lasts one cycle).
REQ-022 STREAM issues one read per cycle while (buffered + in-flight) < 2; -> DRAIN after issuing read for p = WIDTH*HEIGHT-1.
REQ-023 DRAIN -> IDLE on handshake of pix_last pixel; busy drops the following cycle.
REQ-024 Output buffer: 2 entries; pix_valid SHALL not drop and pix_data/pix_x/pix_y SHALL stay stable while pix_valid & ~pix_ready.
REQ-025 With pix_ready held high, throughput SHALL be one pixel per cycle; first pix_valid 2 cycles after entering STREAM.
REQ-026 Deassertion of solve_done during STREAM/DRAIN SHALL be ignored; frame completes.
REQ-027 pix_x wraps WIDTH-1 -> 0 with pix_y increment; no pixel beyond WIDTH*HEIGHT-1 emitted.
REQ-028 rd_solver_id, rd_addr SHALL hold last value when no read issued.

Reset
REQ-029 reset_n low: state IDLE; pix_valid, pix_last, busy = 0; rd_solver_id, rd_addr, pix_x, pix_y, pix_data = 0; buffer emptied; in-flight read discarded.
REQ-030 Reset mid-frame SHALL abort the frame; next start restarts at p = 0.

Configuration
REQ-031 Macro FRAME_READER_PALETTE_EN selects output mapping.
REQ-032 Defined: pix_data = 16-entry RGB565 palette indexed by rd_data_in bits [3:0] (unsigned), registered with data.
REQ-033 Undefined: pix_data = {12'b0, rd_data_in}; palette logic absent; latency unchanged.

Structure
REQ-034 Shared package holds FSM state enum, 16-entry palette constant, pixel-count constant function.
REQ-035 One sub-module, frame_reader_skid: 2-entry valid/ready buffer carrying {pix_data, pix_x, pix_y, pix_last}.

Verification
REQ-036 NUM_SOLVERS=1, WIDTH=8, HEIGHT=2, bank0 addr k = k mod 16, solve_done=1, start, pix_ready=1 -> 16 pixels raw 0..15, consecutive cycles, pix_last on x=7,y=1.
REQ-037 NUM_SOLVERS=4, WIDTH=8, HEIGHT=2 -> read sequence (0,0),(1,0),(2,0),(3,0),(0,1)...(3,3); pix_x/pix_y raster correct.
REQ-038 start with solve_done=0 for 10 cycles then 1 -> no reads during wait, first read cycle after solve_done rises.
REQ-039 pix_ready toggling 1,0,0,1 pattern -> no pixel lost/duplicated, data stable while stalled, order preserved.
REQ-040 reset_n low at pixel 5, release, start -> pix_valid 0 during reset, new frame begins at p=0; second start mid-frame ignored.
REQ-041 PALETTE_EN defined, rd_data_in=4'hF -> pix_data = palette[15]; undefined -> pix_data = 16'h000F.
